// File: rtl/boot_ctrl_wb_pkg.sv
// Shared definitions for the warm-boot request controller.
// Holds the FSM state encoding, the CSR word map, bit positions inside
// the CSR and CMD registers, and the default unlock key.
package boot_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_UNLOCKED = 3'd1,
    ST_COUNT    = 3'd2,
    ST_FIRE     = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam logic [1:0] ADDR_CSR   = 2'd0;
  localparam logic [1:0] ADDR_KEY   = 2'd1;
  localparam logic [1:0] ADDR_DELAY = 2'd2;
  localparam logic [1:0] ADDR_CMD   = 2'd3;

  localparam int CSR_BTN      = 4;
  localparam int CSR_UNLOCKED = 5;
  localparam int CSR_BUSY     = 6;
  localparam int CSR_DONE     = 7;

  localparam int CMD_GO    = 0;
  localparam int CMD_ABORT = 1;

  localparam logic [31:0] UNLOCK_KEY_DEFAULT = 32'hB007CAFE;

endpackage

// File: rtl/boot_ctrl_wb_if.sv
// Wishbone-style CSR bus bundle for boot_ctrl_wb.
// Signals: wb_addr (word address), wb_wdata/wb_rdata (32-bit data),
// wb_we (write enable), wb_cyc (cycle request), wb_ack (acknowledge).
// master: bus initiator (CPU side); slave: the peripheral.
interface boot_ctrl_wb_if;
  logic [1:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic [31:0] wb_rdata;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_ack;

  modport master (
    output wb_addr, wb_wdata, wb_we, wb_cyc,
    input  wb_rdata, wb_ack
  );

  modport slave (
    input  wb_addr, wb_wdata, wb_we, wb_cyc,
    output wb_rdata, wb_ack
  );
endinterface

// File: rtl/boot_ctrl_wb.sv
// Warm-reboot request controller on the CSR bus.
// Firmware writes the unlock key, then CMD.GO; the block holds usb_detach
// for DELAY+1 cycles with boot_sel stable, pulses boot_now once and parks
// in DONE until reset.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   wb          : CSR bus (slave side), one wait state, single-cycle ack
//   btn_val     : filtered button level, reported in CSR[4]
//   boot_sel    : image select, latched at COUNT entry
//   boot_now    : one-cycle boot request
//   usb_detach  : high in COUNT/FIRE/DONE
module boot_ctrl_wb
  import boot_ctrl_pkg::*;
#(
  parameter int          DELAY_WIDTH = 24,
  parameter logic [31:0] UNLOCK_KEY  = UNLOCK_KEY_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  boot_ctrl_wb_if.slave   wb,
  input  logic            btn_val,
  output logic [1:0]      boot_sel,
  output logic            boot_now,
  output logic            usb_detach
);

  state_t                 state, state_next;
  logic [1:0]             sel_reg;
  logic [DELAY_WIDTH-1:0] delay_reg;
  logic [DELAY_WIDTH-1:0] counter;
  logic [1:0]             boot_sel_q;
  logic                   ack_q;
  logic [31:0]            rdata_q;
  logic [31:0]            rd_mux;

  // Write side effects take place on the ack cycle only.
  logic wr_stb, wr_csr, wr_key, wr_delay, wr_cmd;
  logic key_ok, cmd_go, cmd_abort, cfg_wr_en, start, abort_now;

  assign wr_stb    = wb.wb_cyc & wb.wb_we & ack_q;
  assign wr_csr    = wr_stb && (wb.wb_addr == ADDR_CSR);
  assign wr_key    = wr_stb && (wb.wb_addr == ADDR_KEY);
  assign wr_delay  = wr_stb && (wb.wb_addr == ADDR_DELAY);
  assign wr_cmd    = wr_stb && (wb.wb_addr == ADDR_CMD);
  assign key_ok    = (wb.wb_wdata == UNLOCK_KEY);
  assign cmd_go    = wb.wb_wdata[CMD_GO];
  assign cmd_abort = wb.wb_wdata[CMD_ABORT];

  // Config registers freeze once the boot pulse is imminent or done.
  assign cfg_wr_en = (state == ST_IDLE) || (state == ST_UNLOCKED) || (state == ST_COUNT);
  assign start     = (state == ST_UNLOCKED) && (state_next == ST_COUNT);
  assign abort_now = (state == ST_COUNT) && (state_next == ST_IDLE);

  // Bus: one wait state, registered read data that is zero outside ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= wb.wb_cyc & ~ack_q;
      rdata_q <= (wb.wb_cyc & ~ack_q & ~wb.wb_we) ? rd_mux : '0;
    end
  end

  assign wb.wb_ack   = ack_q;
  assign wb.wb_rdata = rdata_q;

  always_comb begin
    rd_mux = '0;
    case (wb.wb_addr)
      ADDR_CSR: begin
        rd_mux[1:0]          = sel_reg;
        rd_mux[CSR_BTN]      = btn_val;
        rd_mux[CSR_UNLOCKED] = (state == ST_UNLOCKED);
        rd_mux[CSR_BUSY]     = (state == ST_COUNT) || (state == ST_FIRE);
        rd_mux[CSR_DONE]     = (state == ST_DONE);
      end
      ADDR_DELAY: rd_mux[DELAY_WIDTH-1:0] = delay_reg;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_reg   <= '0;
      delay_reg <= '0;
    end else if (cfg_wr_en) begin
      if (wr_csr)   sel_reg   <= wb.wb_wdata[1:0];
      if (wr_delay) delay_reg <= wb.wb_wdata[DELAY_WIDTH-1:0];
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (wr_key && key_ok) state_next = ST_UNLOCKED;
      end
      ST_UNLOCKED: begin
        // ABORT overrides GO; anything other than a good key or GO relocks.
        if (wr_cmd)                 state_next = (cmd_go && !cmd_abort) ? ST_COUNT : ST_IDLE;
        else if (wr_key && !key_ok) state_next = ST_IDLE;
        else if (wr_csr || wr_delay) state_next = ST_IDLE;
      end
      ST_COUNT: begin
        if (wr_cmd && cmd_abort) state_next = ST_IDLE;
        else if (counter == '0)  state_next = ST_FIRE;
      end
      ST_FIRE: state_next = ST_DONE;
      ST_DONE: state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    boot_now   = (state == ST_FIRE);
    usb_detach = (state == ST_COUNT) || (state == ST_FIRE) || (state == ST_DONE);
    boot_sel   = boot_sel_q;
  end

  // Countdown and latched image select; the counter stops at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      boot_sel_q <= '0;
      counter    <= '0;
    end else if (start) begin
      boot_sel_q <= sel_reg;
      counter    <= delay_reg;
    end else if (abort_now) begin
      boot_sel_q <= '0;
      counter    <= '0;
    end else if ((state == ST_COUNT) && (counter != '0)) begin
      counter <= counter - DELAY_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_boot_ctrl_wb.sv
module tb_boot_ctrl_wb;
  import boot_ctrl_pkg::*;

  localparam int          DW  = 24;
  localparam logic [31:0] KEY = 32'hB007CAFE;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_val = 1'b0;
  logic [1:0] boot_sel;
  logic       boot_now;
  logic       usb_detach;

  boot_ctrl_wb_if wb();

  boot_ctrl_wb #(.DELAY_WIDTH(DW), .UNLOCK_KEY(KEY)) dut (
    .clk(clk), .rst(rst), .wb(wb.slave), .btn_val(btn_val),
    .boot_sel(boot_sel), .boot_now(boot_now), .usb_detach(usb_detach)
  );

  always #5 clk = ~clk;

  int     tests = 0;
  int     fails = 0;
  longint cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Reference model: the boot is described by the cycle GO was acked and
  // the latched delay; every phase follows from cycle arithmetic.
  typedef enum {P_IDLE, P_COUNT, P_FIRE, P_DONE} phase_t;
  logic          m_unlocked;
  logic [1:0]    m_sel, m_bsel;
  logic [DW-1:0] m_delay;
  longint        m_go;
  longint        m_d;

  typedef struct { bit is_read; logic [31:0] exp; } rd_t;
  typedef struct { longint cyc; logic [1:0] sel; } boot_t;
  rd_t   rdq[$];
  boot_t bootq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic phase_t phase(input longint c);
    if (m_go < 0)            return P_IDLE;
    if (c <= m_go + m_d + 1) return P_COUNT;
    if (c == m_go + m_d + 2) return P_FIRE;
    return P_DONE;
  endfunction

  function automatic logic [31:0] exp_read(input logic [1:0] a, input longint c);
    logic [31:0] r;
    phase_t ph;
    ph = phase(c);
    r  = '0;
    if (a == 2'd0) begin
      r[1:0] = m_sel;
      r[4]   = btn_val;
      r[5]   = (ph == P_IDLE) && m_unlocked;
      r[6]   = (ph == P_COUNT) || (ph == P_FIRE);
      r[7]   = (ph == P_DONE);
    end else if (a == 2'd2) begin
      r[DW-1:0] = m_delay;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_unlocked = 1'b0; m_sel = '0; m_bsel = '0; m_delay = '0;
    m_go = -1; m_d = 0;
    bootq.delete();
  endtask

  // Applies a write that was acked in cycle k.
  task automatic model_write(input logic [1:0] a, input logic [31:0] w, input longint k);
    phase_t ph;
    ph = phase(k);
    if (ph == P_IDLE) begin
      case (a)
        2'd0: begin m_sel = w[1:0]; m_unlocked = 1'b0; end
        2'd1: m_unlocked = (w == KEY);
        2'd2: begin m_delay = w[DW-1:0]; m_unlocked = 1'b0; end
        default: begin
          if (m_unlocked && w[0] && !w[1]) begin
            m_go = k; m_d = longint'(m_delay); m_bsel = m_sel;
            bootq.push_back('{k + longint'(m_delay) + 2, m_sel});
          end
          m_unlocked = 1'b0;
        end
      endcase
    end else if (ph == P_COUNT) begin
      if (a == 2'd0) m_sel = w[1:0];
      if (a == 2'd2) m_delay = w[DW-1:0];
      if (a == 2'd3 && w[1]) begin
        m_go = -1; m_unlocked = 1'b0; m_bsel = '0;
        if (bootq.size() > 0) void'(bootq.pop_back());
      end
    end
  endtask

  // Monitor: per-cycle output checks, read scoreboard, boot pulse scoreboard.
  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    phase_t ph;
    rd_t    r;
    boot_t  b;
    if (!rst) begin
      ph = phase(cyc_n);
      check("usb_detach", 32'(usb_detach), 32'(ph != P_IDLE));
      check("boot_sel", 32'(boot_sel), (ph != P_IDLE) ? 32'(m_bsel) : 32'd0);
      if (wb.wb_ack) begin
        check("ack_single", 32'(prev_ack), 32'd0);
        if (rdq.size() == 0) check("ack_unexpected", 32'd1, 32'd0);
        else begin
          r = rdq.pop_front();
          if (r.is_read) check("rdata", wb.wb_rdata, r.exp);
        end
      end else begin
        check("rdata_no_ack", wb.wb_rdata, 32'd0);
      end
      if (boot_now) begin
        if (bootq.size() == 0) check("boot_now_unexpected", 32'd1, 32'd0);
        else begin
          b = bootq.pop_front();
          check("boot_cycle", 32'(cyc_n), 32'(b.cyc));
          check("boot_sel_at_fire", 32'(boot_sel), 32'(b.sel));
        end
      end
      if (bootq.size() > 0 && bootq[0].cyc < cyc_n) begin
        check("boot_now_missing", 32'd0, 32'd1);
        void'(bootq.pop_front());
      end
    end
    prev_ack = wb.wb_ack;
  end

  task automatic bus(input logic [1:0] a, input bit we, input logic [31:0] w);
    longint k;
    int     n;
    @(negedge clk);
    btn_val     = 1'($urandom_range(0, 1));
    wb.wb_addr  = a;
    wb.wb_we    = we;
    wb.wb_wdata = w;
    wb.wb_cyc   = 1'b1;
    rdq.push_back('{!we, exp_read(a, cyc_n)});
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!wb.wb_ack && n < 4);
    if (!wb.wb_ack) begin
      check("ack_timeout", 32'd0, 32'd1);
      rdq.delete();
      wb.wb_cyc = 1'b0;
    end else begin
      k = cyc_n;
      @(posedge clk); #1;
      if (we) model_write(a, w, k);
      wb.wb_cyc = 1'b0;
      wb.wb_we  = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    check("reset_boot_now", 32'(boot_now), 32'd0);
    check("reset_usb_detach", 32'(usb_detach), 32'd0);
    check("reset_boot_sel", 32'(boot_sel), 32'd0);
    check("reset_ack", 32'(wb.wb_ack), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_boot();
    int n;
    n = 0;
    while (bootq.size() > 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (bootq.size() > 0) check("boot_wait_timeout", 32'd0, 32'd1);
    idle(2);
  endtask

  task automatic rand_op();
    logic [1:0]  a;
    logic [31:0] w;
    a = 2'($urandom_range(0, 3));
    case ($urandom_range(0, 9))
      0, 1, 2: w = KEY;
      3:       w = $urandom;
      default: w = $urandom_range(0, 3);
    endcase
    if (a == 2'd2) w = {8'($urandom), 24'($urandom_range(0, 40))};
    bus(a, ($urandom_range(0, 3) != 0), w);
  endtask

  initial begin
    wb.wb_addr = '0; wb.wb_wdata = '0; wb.wb_we = 1'b0; wb.wb_cyc = 1'b0;
    model_reset();
    do_reset();
    bus(2'd0, 1'b0, '0);

    // Unlock and boot with DELAY=5, sel=2
    bus(2'd2, 1'b1, 32'd5);
    bus(2'd0, 1'b1, 32'd2);
    bus(2'd1, 1'b1, KEY);
    bus(2'd0, 1'b0, '0);
    bus(2'd3, 1'b1, 32'd1);
    wait_boot();
    bus(2'd0, 1'b0, '0);
    bus(2'd3, 1'b1, 32'd2);
    bus(2'd0, 1'b0, '0);
    do_reset();

    // GO while locked
    bus(2'd3, 1'b1, 32'd1);
    idle(100);
    bus(2'd0, 1'b0, '0);

    // Wrong key relocks; config write relocks
    bus(2'd1, 1'b1, KEY);
    bus(2'd1, 1'b1, 32'h12345678);
    bus(2'd3, 1'b1, 32'd1);
    bus(2'd0, 1'b0, '0);
    bus(2'd1, 1'b1, KEY);
    bus(2'd2, 1'b1, 32'd3);
    bus(2'd3, 1'b1, 32'd1);
    bus(2'd0, 1'b0, '0);
    bus(2'd2, 1'b0, '0);

    // Abort during a long countdown
    bus(2'd2, 1'b1, 32'd1000);
    bus(2'd0, 1'b1, 32'd3);
    bus(2'd1, 1'b1, KEY);
    bus(2'd3, 1'b1, 32'd1);
    idle(10);
    bus(2'd1, 1'b1, 32'h0);
    bus(2'd0, 1'b0, '0);
    bus(2'd3, 1'b1, 32'd2);
    idle(5);
    bus(2'd0, 1'b0, '0);

    // DELAY=0, then GO|ABORT together
    bus(2'd2, 1'b1, 32'd0);
    bus(2'd1, 1'b1, KEY);
    bus(2'd3, 1'b1, 32'd1);
    wait_boot();
    do_reset();
    bus(2'd1, 1'b1, KEY);
    bus(2'd3, 1'b1, 32'd3);
    idle(5);
    bus(2'd0, 1'b0, '0);

    // Reset in the middle of a countdown
    bus(2'd2, 1'b1, 32'd50);
    bus(2'd1, 1'b1, KEY);
    bus(2'd3, 1'b1, 32'd1);
    idle(10);
    do_reset();
    idle(60);
    bus(2'd0, 1'b0, '0);

    // Randomized sessions
    for (int it = 0; it < 40; it++) begin
      do_reset();
      if ($urandom_range(0, 1) == 1) begin
        bus(2'd2, 1'b1, 32'($urandom_range(0, 30)));
        bus(2'd0, 1'b1, 32'($urandom_range(0, 3)));
        bus(2'd1, 1'b1, KEY);
        if ($urandom_range(0, 3) == 0) rand_op();
        bus(2'd3, 1'b1, 32'($urandom_range(0, 3)));
      end
      for (int j = 0; j < 10; j++) begin
        rand_op();
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
      end
      wait_boot();
      bus(2'd0, 1'b0, '0);
    end

    idle(5);
    check("boot_queue_empty", 32'(bootq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/boot_ctrl_wb.md
Name: boot_ctrl_wb

Overview:
Wishbone CSR peripheral that lets firmware request a warm reboot into a chosen image. It is the initiator side of the external boot-request interface (boot_sel/boot_now) consumed by the DFU/button helper. A key unlock guards the request, and a programmable countdown holds USB detach asserted before the boot pulse so the host sees a clean disconnect. It sits on the SoC peripheral bus next to the USB core.

Parameters:
DELAY_WIDTH, 24, width of countdown register and counter (cycles between command and boot pulse)
UNLOCK_KEY, 32'hB007CAFE, value that must be written to KEY before a boot command is accepted

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
wb_addr  in  2  register word address
wb_rdata  out  32  read data, zero when wb_ack=0
wb_wdata  in  32  write data
wb_we  in  1  write enable
wb_cyc  in  1  bus cycle request
wb_ack  out  1  single-cycle acknowledge
btn_val  in  1  filtered button level from the button/DFU helper (status only)
boot_sel  out  2  warmboot image select, stable from COUNT entry through FIRE
boot_now  out  1  one-cycle boot request pulse
usb_detach  out  1  high during COUNT/FIRE/DONE to force USB pull-up off

Behaviour:
- Reset: all outputs 0; state IDLE; sel_reg=0; delay_reg=0; counter=0.
- Bus: wb_ack <= wb_cyc & ~wb_ack (1 wait state, ack exactly 1 cycle); write side-effects occur on the ack cycle; wb_rdata is registered and valid only with ack, else 0.
- Map (word addr):
  - 0 CSR: RW [1:0] sel_reg; RO [4] btn_val, [5] unlocked, [6] busy (COUNT|FIRE), [7] done.
  - 1 KEY: WO; value==UNLOCK_KEY -> unlocked, any other value -> locked. Reads 0.
  - 2 DELAY: RW [DELAY_WIDTH-1:0]; upper bits read 0.
  - 3 CMD: WO; bit0 GO, bit1 ABORT. Reads 0.
- States: IDLE, UNLOCKED, COUNT, FIRE, DONE.
  - IDLE: correct KEY write -> UNLOCKED. GO is ignored.
  - UNLOCKED: CMD GO=1 -> COUNT; latch boot_sel<=sel_reg and counter<=delay_reg. Any write to CSR or DELAY, a wrong KEY, or CMD without GO -> IDLE (relock). A repeated correct KEY write stays UNLOCKED.
  - COUNT: usb_detach=1; counter decrements each cycle; when counter==0, go to FIRE next cycle. DELAY=0 means exactly one COUNT cycle. ABORT -> IDLE, usb_detach drops the next cycle, boot_sel returns to 0. KEY/CSR/DELAY writes are acked but have no effect on the pending request.
  - FIRE: boot_now=1 for exactly one cycle, with boot_sel already stable at least DELAY+1 cycles -> DONE.
  - DONE: terminal; usb_detach stays 1, boot_now=0. All writes are acked and ignored. Only rst leaves this state (the device normally reboots here).
- If GO and ABORT are both set in one write from UNLOCKED, ABORT wins -> IDLE.
- rst mid-COUNT: immediate return to reset values; no boot_now is ever emitted.
- Counter never wraps: decrement happens only while nonzero.
- Unmapped behaviour: none; all 4 addresses decode.

Decomposition:
- Shared package boot_ctrl_pkg: state encoding constants (ST_IDLE..ST_DONE), register address constants, CSR bit positions, UNLOCK_KEY default.
- No sub-module needed. The bus decode and FSM/counter live in one file; the countdown could be split into a trivial load/dec counter, but that is not warranted.

Test Plan:
- Unlock + boot: write DELAY=5, CSR sel=2'b10, KEY=B007CAFE, CMD=1 -> usb_detach rises the cycle after CMD ack, boot_sel=2'b10, boot_now pulses exactly 6 cycles after COUNT entry for 1 cycle, CSR reads done=1.
- Locked GO: without KEY, CMD=1 -> no state change, CSR busy=0, boot_now never asserts over 100 cycles.
- Wrong key / relock: KEY=B007CAFE then KEY=12345678, CMD=1 -> stays IDLE. Separately, KEY ok then DELAY write then CMD=1 -> stays IDLE.
- Abort: DELAY=1000, unlock, GO, then CMD=2 after 10 cycles -> usb_detach falls, boot_sel=0, no boot_now, state IDLE (unlocked=0).
- DELAY=0 and GO|ABORT=3: DELAY=0 + GO -> boot_now 1 cycle after COUNT entry. CMD=3 from UNLOCKED -> IDLE, no detach.
- Reset mid-COUNT + bus: assert rst during COUNT -> all outputs 0 next cycle, no boot_now. Every access gives a single-cycle wb_ack and rdata=0 outside ack; CSR[4] tracks btn_val toggles.
